// File: rtl/mdu_pkg.sv
// Shared encodings, state type and default latencies for the mult/div unit.
package mdu_pkg;

   localparam int unsigned DATA_W = 32;

   // MultDivOp encodings as driven by the ID/EX register
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
module md_arith
   import mdu_pkg::*;
(
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] hi_res,
   output logic [DATA_W-1:0] lo_res,
   output logic              div_zero
);

   logic signed [2*DATA_W-1:0] a_sx;
   logic signed [2*DATA_W-1:0] b_sx;
   logic [2*DATA_W-1:0]        prod_s;
   logic [2*DATA_W-1:0]        prod_u;
   logic                       is_signed_div;
   logic                       a_neg;
   logic                       b_neg;
   logic [DATA_W-1:0]          a_mag;
   logic [DATA_W-1:0]          b_mag;
   logic [DATA_W-1:0]          b_div;
   logic [DATA_W-1:0]          q_mag;
   logic [DATA_W-1:0]          r_mag;
   logic [DATA_W-1:0]          quo;
   logic [DATA_W-1:0]          rem;

   // Products: sign-extended operands give the signed 64-bit result directly
   always_comb begin
      a_sx   = {{DATA_W{a[DATA_W-1]}}, a};
      b_sx   = {{DATA_W{b[DATA_W-1]}}, b};
      prod_s = a_sx * b_sx;
      prod_u = {DATA_W'(0), a} * {DATA_W'(0), b};
   end

   // Division on magnitudes; signs reapplied so quotient truncates toward zero
   // and the remainder follows the dividend. Most-negative / -1 wraps to itself.
   always_comb begin
      is_signed_div = (op == MD_DIV);
      a_neg         = is_signed_div & a[DATA_W-1];
      b_neg         = is_signed_div & b[DATA_W-1];
      a_mag         = a_neg ? (DATA_W'(0) - a) : a;
      b_mag         = b_neg ? (DATA_W'(0) - b) : b;
      b_div         = (b_mag == DATA_W'(0)) ? DATA_W'(1) : b_mag;
      q_mag         = a_mag / b_div;
      r_mag         = a_mag % b_div;
      quo           = (a_neg ^ b_neg) ? (DATA_W'(0) - q_mag) : q_mag;
      rem           = a_neg ? (DATA_W'(0) - r_mag) : r_mag;
   end

   // Result select and zero-divisor flag
   always_comb begin
      hi_res   = '0;
      lo_res   = '0;
      div_zero = op[1] & (b == DATA_W'(0));
      case (op)
         MD_MULT: begin
            hi_res = prod_s[2*DATA_W-1:DATA_W];
            lo_res = prod_s[DATA_W-1:0];
         end
         MD_MULTU: begin
            hi_res = prod_u[2*DATA_W-1:DATA_W];
            lo_res = prod_u[DATA_W-1:0];
         end
         default: begin
            hi_res = rem;
            lo_res = quo;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle mult/div sequencer owning the HI/LO registers.
module mult_div_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              hilo_we,
   input  logic              hilo_sel,
   input  logic [DATA_W-1:0] wdata,
   input  logic              flush,
   input  logic              md_use_id,
   output logic              busy,
   output logic              stall_req,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int unsigned MAX_LAT  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_RAW  = $clog2(MAX_LAT + 1);
   localparam int unsigned CNT_W    = (CNT_RAW > 4) ? CNT_RAW : 4;
   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] hi_res;
   logic [DATA_W-1:0] lo_res;
   logic              div_zero;

   md_arith u_arith (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .hi_res   (hi_res),
      .lo_res   (lo_res),
      .div_zero (div_zero)
   );

   // State, counter, latched operands and HI/LO registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next state: accept start/mthi/mtlo in IDLE, count down and commit in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (!flush) begin
               if (start) begin
                  state_d = ST_RUN;
                  op_d    = op;
                  a_d     = a;
                  b_d     = b;
                  cnt_d   = op[1] ? DIV_CNT : MULT_CNT;
               end else if (hilo_we) begin
                  if (hilo_sel) hi_d = wdata;
                  else          lo_d = wdata;
               end
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (!div_zero) begin
                  hi_d = hi_res;
                  lo_d = lo_res;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status and hazard request; stall covers the start cycle itself
   assign busy      = (state_q == ST_RUN);
   assign stall_req = md_use_id & (busy | start);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl against a 64-bit arithmetic model.
module tb_mult_div_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hilo_we;
   logic        hilo_sel;
   logic [31:0] wdata;
   logic        flush;
   logic        md_use_id;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   always #5 clk = ~clk;

   mult_div_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata), .flush(flush),
      .md_use_id(md_use_id), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
   );

   // Reference: the architectural result of one mult/div, applied to hi_m/lo_m
   function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, sp, sq, sr;
      longint unsigned ux, uy, up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         2'd0: begin sp = sx * sy; hi_m = sp[63:32]; lo_m = sp[31:0]; end
         2'd1: begin up = ux * uy; hi_m = up[63:32]; lo_m = up[31:0]; end
         2'd2: if (y != 0) begin sq = sx / sy; sr = sx % sy; lo_m = sq[31:0]; hi_m = sr[31:0]; end
         default: if (y != 0) begin lo_m = x / y; hi_m = x % y; end
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] o);
      return o[1] ? DC : MC;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op in IDLE and count busy cycles until it finishes (bounded)
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 60) begin
         n++;
         tick();
      end
   endtask

   task automatic hilo_write(input logic sel, input logic [31:0] d);
      hilo_we = 1'b1; hilo_sel = sel; wdata = d;
      tick();
      hilo_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; md_use_id = 1'b1; start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
      #1;
      n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", stall_req); end
      tick(); tick();
      start = 1'b0; md_use_id = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
      rst = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
      hi_m = '0; lo_m = '0;
   endtask

   task automatic test_directed();
      logic [1:0]  vo [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
      logic [31:0] va [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
      logic [31:0] vb [5] = '{32'd3, 32'd3, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] eh [5] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'h80000000, 32'h0};
      logic [31:0] el [5] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'h0, 32'h80000000};
      int n;
      for (int i = 0; i < 5; i++) begin
         run_op(vo[i], va[i], vb[i], n);
         n_cmp++; if (n !== lat_of(vo[i])) begin n_bad++; $display("FAIL directed_lat[%0d]: got %0d want %0d", i, n, lat_of(vo[i])); end
         n_cmp++; if (hi !== eh[i] || lo !== el[i]) begin n_bad++; $display("FAIL directed_res[%0d]: got %h/%h want %h/%h", i, hi, lo, eh[i], el[i]); end
         hi_m = eh[i]; lo_m = el[i];
      end
   endtask

   task automatic test_div_zero();
      int n;
      hilo_write(1'b0, 32'h1234);
      lo_m = 32'h1234;
      n_cmp++; if (lo !== 32'h1234) begin n_bad++; $display("FAIL mtlo: got %h want 00001234", lo); end
      run_op(2'd2, 32'd77, 32'd0, n);
      n_cmp++; if (n !== DC) begin n_bad++; $display("FAIL divzero_lat: got %0d want %0d", n, DC); end
      n_cmp++; if (hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL divzero_hilo: got %h/%h want %h/%h", hi, lo, hi_m, lo_m); end
      hilo_write(1'b1, 32'hCAFE0001);
      hi_m = 32'hCAFE0001;
      run_op(2'd3, 32'hFFFF0000, 32'd0, n);
      n_cmp++; if (hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL divuzero_hilo: got %h/%h want %h/%h", hi, lo, hi_m, lo_m); end
   endtask

   task automatic test_stall();
      int sc;
      md_use_id = 1'b1;
      #1;
      n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL stall_idle: got %b want 0", stall_req); end
      op = 2'd0; a = 32'd1000; b = 32'hFFFFFFF0; start = 1'b1;
      #1;
      sc = 0;
      for (int k = 0; k < 20; k++) begin
         if (stall_req) sc++;
         tick();
         start = 1'b0;
         #1;
      end
      n_cmp++; if (sc !== 1 + MC) begin n_bad++; $display("FAIL stall_cycles: got %0d want %0d", sc, 1 + MC); end
      n_cmp++; if (stall_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_after: got stall=%b busy=%b want 0/0", stall_req, busy); end
      model_op(2'd0, 32'd1000, 32'hFFFFFFF0);
      n_cmp++; if (hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL stall_res: got %h/%h want %h/%h", hi, lo, hi_m, lo_m); end
      md_use_id = 1'b0;
   endtask

   task automatic test_flush();
      int n;
      hilo_write(1'b1, 32'h55);
      hilo_write(1'b0, 32'h55);
      hi_m = 32'h55; lo_m = 32'h55;
      op = 2'd0; a = 32'd123; b = 32'd456; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
      n_cmp++; if (hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL flush_hilo: got %h/%h want %h/%h", hi, lo, hi_m, lo_m); end
      repeat (MC) tick();
      n_cmp++; if (hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL flush_nocommit: got %h/%h want %h/%h", hi, lo, hi_m, lo_m); end
      // flush in IDLE masks both start and an mthi/mtlo
      flush = 1'b1; start = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'hBAD0BAD0;
      tick();
      flush = 1'b0; start = 1'b0; hilo_we = 1'b0;
      n_cmp++; if (busy !== 1'b0 || lo !== lo_m) begin n_bad++; $display("FAIL flush_idle: got busy=%b lo=%h want 0/%h", busy, lo, lo_m); end
      run_op(2'd0, 32'hFFFFFF85, 32'd456, n);
      model_op(2'd0, 32'hFFFFFF85, 32'd456);
      n_cmp++; if (n !== MC || hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL flush_restart: got n=%0d %h/%h want %0d %h/%h", n, hi, lo, MC, hi_m, lo_m); end
   endtask

   task automatic test_rst_mid();
      op = 2'd3; a = 32'd99; b = 32'd7; start = 1'b1;
      tick(); start = 1'b0;
      repeat (4) tick();
      rst = 1'b1; flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      hi_m = '0; lo_m = '0;
      n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL rst_mid: got busy=%b %h/%h want 0 0/0", busy, hi, lo); end
      repeat (DC) tick();
      n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL rst_mid_nocommit: got %h/%h want 0/0", hi, lo); end
   endtask

   task automatic test_start_hilo();
      int n;
      hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'hDEADBEEF;
      run_op(2'd1, 32'd7, 32'd9, n);
      hilo_we = 1'b0;
      model_op(2'd1, 32'd7, 32'd9);
      n_cmp++; if (n !== MC || hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL start_hilo: got n=%0d %h/%h want %0d %h/%h", n, hi, lo, MC, hi_m, lo_m); end
   endtask

   task automatic test_back_to_back();
      int n;
      run_op(2'd3, 32'd1000, 32'd7, n);
      model_op(2'd3, 32'd1000, 32'd7);
      n_cmp++; if (n !== DC || hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL b2b_first: got n=%0d %h/%h want %0d %h/%h", n, hi, lo, DC, hi_m, lo_m); end
      run_op(2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, n);
      model_op(2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF);
      n_cmp++; if (n !== MC || hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL b2b_second: got n=%0d %h/%h want %0d %h/%h", n, hi, lo, MC, hi_m, lo_m); end
      // a start asserted while running must not restart or retarget the op
      op = 2'd1; a = 32'd11; b = 32'd13; start = 1'b1;
      tick();
      op = 2'd2; a = 32'd500; b = 32'd3;
      tick(); tick();
      start = 1'b0;
      n = 2;
      while (busy && n < 60) begin n++; tick(); end
      model_op(2'd1, 32'd11, 32'd13);
      n_cmp++; if (n !== MC || hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL run_ignore_start: got n=%0d %h/%h want %0d %h/%h", n, hi, lo, MC, hi_m, lo_m); end
   endtask

   task automatic test_random();
      int          n;
      logic [1:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) < 2) begin
            x = $urandom;
            o[0] = 1'($urandom_range(0, 1));
            hilo_write(o[0], x);
            if (o[0]) hi_m = x; else lo_m = x;
            n_cmp++; if (hi !== hi_m || lo !== lo_m) begin n_bad++; $display("FAIL rand_mthilo[%0d]: got %h/%h want %h/%h", i, hi, lo, hi_m, lo_m); end
         end else begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(20, 31);
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            run_op(o, x, y, n);
            model_op(o, x, y);
            n_cmp++; if (n !== lat_of(o) || hi !== hi_m || lo !== lo_m) begin
               n_bad++;
               $display("FAIL rand_op[%0d] op=%0d a=%h b=%h: got n=%0d %h/%h want %0d %h/%h", i, o, x, y, n, hi, lo, lat_of(o), hi_m, lo_m);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      hilo_we = 1'b0; hilo_sel = 1'b0; wdata = '0; flush = 1'b0; md_use_id = 1'b0;
      test_reset();
      test_directed();
      test_div_zero();
      test_stall();
      test_flush();
      test_rst_mid();
      test_start_hilo();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the 5-stage MIPS pipeline. It accepts the EX-stage mult/div start, op and HI/LO-write controls from the ID/EX register, runs a fixed-latency operation, commits HI/LO on completion and raises a stall request to the hazard unit while a HI/LO consumer sits in ID. An exception flush aborts an in-flight operation without touching HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu (≥1)
- DIV_CYCLES, 10, busy duration of div/divu (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  EX-stage MultDivStart
- op  in  2  EX-stage MultDivOp: 00 mult, 01 multu, 10 div, 11 divu
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- hilo_we  in  1  EX-stage mthi/mtlo write enable
- hilo_sel  in  1  1 = HI, 0 = LO target of hilo_we
- wdata  in  32  mthi/mtlo data
- flush  in  1  exception/eret flush of EX stage
- md_use_id  in  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall_req  out  1  = md_use_id & (busy | start); combinational
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. Counter cnt (4 bits min, sized for max(MULT_CYCLES, DIV_CYCLES)); latched op_q, a_q, b_q.
- IDLE, start=1, flush=0: latch op/a/b, cnt ← latency of op, → RUN.
- IDLE, hilo_we=1, start=0, flush=0: write wdata to HI (hilo_sel=1) or LO.
- start and hilo_we together: start wins, write dropped.
- flush=1 in IDLE: start and hilo_we ignored.
- RUN: cnt decrements each edge; on the edge with cnt==1 commit result, → IDLE.
- RUN, start or hilo_we: ignored (hazard unit guarantees none; no queueing).
- RUN, flush=1: → IDLE immediately, HI/LO unchanged, no commit.
- Results: mult {HI,LO} = signed a×b (64-bit); multu unsigned; div LO = quotient, HI = remainder, truncating toward zero, remainder sign = dividend sign; divu unsigned.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor 0 (div/divu): op runs full latency, commit suppressed, HI/LO unchanged.
- busy = (state==RUN).
- Reset: state IDLE, cnt=0, hi=0, lo=0, op_q/a_q/b_q=0, busy=0; stall_req follows md_use_id & start.

## Timing
- start sampled at edge E0: busy=1 in cycles after E0 through E0+N edges; HI/LO new values and busy=0 visible after edge E0+N (N = MULT_CYCLES or DIV_CYCLES).
- Back-to-back: start on the same edge busy falls is legal (state IDLE that cycle) → new op begins next edge.
- mthi/mtlo: HI/LO updated one edge after hilo_we sampled.
- stall_req combinational, same cycle as start to cover the start-cycle ID consumer.
- rst has priority over flush, start, hilo_we.

## Structure
- Package mdu_pkg: op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU, state enum, default latencies.
- Sub-module md_arith: combinational, from op_q/a_q/b_q produces hi_res, lo_res, div_zero; controller instantiates one. No other hierarchy.

## Test plan
- mult a=0xFFFFFFFE(-2), b=3 → after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands → hi=0x2, lo=0xFFFFFFFA.
- div a=-7, b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 0x80000000/0xFFFFFFFF → lo=0, hi=0x80000000; div 0x80000000/-1 → lo=0x80000000, hi=0.
- mtlo 0x1234 then div by 0 → busy 10 cycles, lo stays 0x1234, hi stays 0.
- md_use_id=1 during start cycle and all busy cycles → stall_req=1 exactly those 1+N cycles, 0 after commit.
- Flush in busy cycle 3 of mult with hi=lo=0x55 → busy drops next edge, hi=lo=0x55; new mult starts cleanly afterward.
- rst asserted mid-div → next edge busy=0, hi=lo=0; start+hilo_we same cycle → hilo write dropped, op runs.
